// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/abort request, operands and result bundle for the serial adder
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, abort, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, abort, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one FA cell LSB-first over WIDTH-bit operands
module FA (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, a_sh_nx;
    logic [WIDTH-1:0] b_sh, b_sh_nx;
    logic [WIDTH-1:0] s_sh, s_sh_nx;
    logic [WIDTH-1:0] sum_r, sum_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             c, c_nx;
    logic             cout_r, cout_nx;
    logic             fa_s, fa_c;

    FA u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (c),
        .Sum  (fa_s),
        .Cout (fa_c)
    );

    // state and datapath registers; reset clears everything, losing any in-flight result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            cout_r <= 1'b0;
        end else begin
            state  <= state_nx;
            a_sh   <= a_sh_nx;
            b_sh   <= b_sh_nx;
            s_sh   <= s_sh_nx;
            sum_r  <= sum_nx;
            cnt    <= cnt_nx;
            c      <= c_nx;
            cout_r <= cout_nx;
        end
    end

    // next-state: load on start outside RUN, one bit per RUN cycle, abort wins over completion
    always_comb begin
        state_nx = state;
        a_sh_nx  = a_sh;
        b_sh_nx  = b_sh;
        s_sh_nx  = s_sh;
        sum_nx   = sum_r;
        cnt_nx   = cnt;
        c_nx     = c;
        cout_nx  = cout_r;
        case (state)
            IDLE, DONE: begin
                state_nx = bus.start ? RUN : IDLE;
                if (bus.start) begin
                    a_sh_nx = bus.a;
                    b_sh_nx = bus.b;
                    c_nx    = bus.cin;
                    s_sh_nx = '0;
                    cnt_nx  = '0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                end else begin
                    a_sh_nx = a_sh >> 1;
                    b_sh_nx = b_sh >> 1;
                    s_sh_nx = (s_sh >> 1) | {fa_s, {(WIDTH-1){1'b0}}};
                    c_nx    = fa_c;
                    cnt_nx  = cnt + CW'(1);
                    if (cnt == LAST) begin
                        state_nx = DONE;
                        sum_nx   = s_sh_nx;
                        cout_nx  = fa_c;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for 8-bit directed and 4-bit exhaustive additions
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   nchk = 0;
    int   nerr = 0;
    int   d8 = 0;
    int   d4 = 0;
    logic [8:0] q8[$];
    logic [4:0] q4[$];

    serial_adder_ctrl_if #(.WIDTH(8)) if8();
    serial_adder_ctrl_if #(.WIDTH(4)) if4();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard for the 8-bit instance
    always @(negedge clk) begin
        if (rst_n && if8.done) begin
            d8++;
            if (q8.size() == 0) chk("dut8 unexpected done", 1, 0);
            else chk("dut8 result", {if8.cout, if8.sum}, q8.pop_front());
            chk("dut8 busy with done", if8.busy, 0);
        end
    end

    // scoreboard for the 4-bit instance
    always @(negedge clk) begin
        if (rst_n && if4.done) begin
            d4++;
            if (q4.size() == 0) chk("dut4 unexpected done", 1, 0);
            else chk("dut4 result", {if4.cout, if4.sum}, q4.pop_front());
        end
    end

    task automatic start8(logic [7:0] a, logic [7:0] b, logic ci, bit push);
        @(negedge clk);
        if8.start = 1'b1;
        if8.a = a;
        if8.b = b;
        if8.cin = ci;
        if (push) q8.push_back(9'(a) + 9'(b) + 9'(ci));
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    task automatic wait_done8(output int n);
        int k = 0;
        n = 0;
        while (!if8.done && k < 40) begin
            if (if8.busy) n++;
            k++;
            @(negedge clk);
        end
        chk("dut8 done seen", if8.done, 1);
    endtask

    task automatic wait_done4();
        int k = 0;
        while (!if4.done && k < 20) begin
            k++;
            @(negedge clk);
        end
        chk("dut4 done seen", if4.done, 1);
    endtask

    initial begin
        int n;
        int d;
        {if8.start, if8.abort, if8.a, if8.b, if8.cin} = '0;
        {if4.start, if4.abort, if4.a, if4.b, if4.cin} = '0;
        #2 rst_n = 1'b0;
        #1 chk("reset outputs", {if8.busy, if8.done, if8.cout, if8.sum}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle after reset", {if8.busy, if8.done}, 0);

        start8(8'h5A, 8'h3C, 1'b0, 1'b1);
        chk("busy after start", if8.busy, 1);
        wait_done8(n);
        chk("basic latency", n, 8);
        chk("basic sum", {if8.cout, if8.sum}, 9'h096);
        repeat (3) @(negedge clk);
        chk("basic hold", {if8.done, if8.cout, if8.sum}, 10'h096);

        start8(8'h01, 8'h02, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        if8.abort = 1'b1;
        @(negedge clk);
        if8.abort = 1'b0;
        chk("abort E4 state", {if8.busy, if8.done, if8.sum}, 10'h096);
        d = d8;
        repeat (12) @(negedge clk);
        chk("abort E4 no done", d8, d);

        start8(8'h01, 8'h02, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        if8.abort = 1'b1;
        @(negedge clk);
        if8.abort = 1'b0;
        chk("abort E8 state", {if8.busy, if8.done, if8.sum}, 10'h096);
        repeat (4) @(negedge clk);
        chk("abort E8 no done", d8, d);

        start8(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_done8(n);
        chk("carry1", {if8.cout, if8.sum}, 9'h100);
        start8(8'hFF, 8'hFF, 1'b1, 1'b1);
        wait_done8(n);
        chk("carry2", {if8.cout, if8.sum}, 9'h1FF);

        start8(8'h10, 8'h20, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        if8.start = 1'b1;
        if8.a = 8'hFF;
        if8.b = 8'hFF;
        @(negedge clk);
        if8.start = 1'b0;
        wait_done8(n);
        chk("start while busy", {if8.cout, if8.sum}, 9'h030);

        @(negedge clk);
        if8.start = 1'b1;
        if8.a = 8'h81;
        if8.b = 8'h42;
        if8.cin = 1'b1;
        q8.push_back(9'h0C4);
        @(negedge clk);
        wait_done8(n);
        chk("b2b first latency", n, 8);
        if8.a = 8'hC3;
        if8.b = 8'h7E;
        if8.cin = 1'b0;
        q8.push_back(9'h141);
        @(negedge clk);
        if8.start = 1'b0;
        chk("b2b restart busy", {if8.busy, if8.done}, 2'b10);
        wait_done8(n);
        chk("b2b second latency", n, 8);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    if4.start = 1'b1;
                    if4.a = 4'(a);
                    if4.b = 4'(b);
                    if4.cin = 1'(c);
                    q4.push_back(5'(a + b + c));
                    @(negedge clk);
                    if4.start = 1'b0;
                    wait_done4();
                end

        start8(8'h33, 8'h44, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async reset mid-run", {if8.busy, if8.done, if8.cout, if8.sum}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        d = d8;
        repeat (12) @(negedge clk);
        chk("idle after mid-run reset", {if8.busy, if8.done}, 0);
        chk("no done after reset", d8, d);

        chk("dut8 queue drained", q8.size(), 0);
        chk("dut4 queue drained", q4.size(), 0);
        chk("dut4 done count", d4, 512);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that sequences one instance of the team's one-bit full-adder cell `FA` (ports A, B, Cin, Sum, Cout) over WIDTH-bit operands. It captures the operands on a start handshake and feeds one bit pair plus the stored carry into `FA` per clock. It collects the sum bits and reports the WIDTH-bit result and final carry with a one-cycle done pulse. It lets multi-bit additions share a single adder cell instead of a ripple chain.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  single clock, rising-edge active.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- abort  in  1  synchronous cancel; effective only in RUN.
- a  in  WIDTH  operand A, sampled with an accepted start.
- b  in  WIDTH  operand B, sampled with an accepted start.
- cin  in  1  carry-in, sampled with an accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  registered result; holds until the next completion.
- cout  out  1  registered final carry; holds until the next completion.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset forces IDLE.
- **Internal state:** shift registers a_sh and b_sh (WIDTH bits each), carry register c, sum shift register s_sh (WIDTH bits), and bit counter cnt of width clog2(WIDTH).
- **IDLE or DONE with start=1:** load a_sh=a, b_sh=b, c=cin, s_sh=0 and cnt=0, then go to RUN.
- **IDLE with start=0:** stay in IDLE.
- **DONE with start=0:** go to IDLE.
- **`FA` inputs:** A=a_sh[0], B=b_sh[0], Cin=c, driven combinationally from the registers.
- **RUN, each edge with abort=0:**
  - a_sh and b_sh shift right.
  - s_sh shifts right with FA.Sum entering the MSB.
  - c takes FA.Cout.
  - cnt increments.
- **RUN, edge with cnt==WIDTH-1 and abort=0:** perform the shift as above, then load sum with the fully shifted value and cout with FA.Cout, and go to DONE.
- **RUN with abort=1:** go to IDLE. sum and cout keep their previous values and done is not asserted. abort has priority over the cnt==WIDTH-1 completion on the same edge.
- start and a/b/cin are ignored while in RUN. abort is ignored outside RUN.
- **Arithmetic:** {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag is produced.
- **Reset values:**
  - busy=0, done=0, sum=0, cout=0.
  - All internal registers 0, state IDLE.
  - Asserting rst_n low mid-RUN aborts immediately and asynchronously. The result is lost and no done pulse is produced.

## Timing
- Edge E0 accepts start. Bit i (LSB first) is processed at edge E(i+1).
- Edge E(WIDTH) completes the addition. sum/cout update and done=1, busy=0 for the cycle after E(WIDTH).
- busy=1 from after E0 through E(WIDTH). Latency from start to done is WIDTH cycles.
- done returns to 0 after E(WIDTH+1).
- start held high at E(WIDTH+1), which is the DONE state, begins the next operation. Back-to-back throughput is one result per WIDTH+1 cycles.
- done and busy are never high together.
- No combinational path from inputs to outputs.

## Test plan
- **Reset:** assert rst_n=0 mid-RUN, asynchronously between edges -> busy, done, sum and cout read 0 immediately; after release, the FSM is in IDLE and stays idle until start.
- **Basic add, WIDTH=8:** a=8'h5A, b=8'h3C, cin=0, start pulsed at E0 -> busy for 8 cycles, done pulse after E8, sum=8'h96, cout=0; values hold after done.
- **Carry propagation:** a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- **Start while busy:** start with a=8'h10, b=8'h20, then pulse start with a=8'hFF, b=8'hFF at E3 -> second start ignored; result sum=8'h30, cout=0 after E8.
- **Abort and back-to-back:**
  - abort=1 at E4 of a run following the 8'h96 result -> IDLE, no done pulse, sum stays 8'h96.
  - Then start held high across E8/E9 of a fresh run -> second run begins at E9 with its done pulse after E17.
- **Exhaustive, WIDTH=4:** all 512 combinations of a, b and cin -> {cout,sum} equals a+b+cin for every case; exactly one done pulse per accepted start.
